// File: rtl/vectored_irq_controller.sv
// Memory-mapped interrupt controller with per-channel edge/level sensing and an input synchroniser.
// Define IRQ_VECTOR_EN to add the fixed-priority VECTOR register, acknowledge write and irq_vector.
module vectored_irq_controller #(
  parameter int NUM_IRQS    = 15,
  parameter int SYNC_STAGES = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQS-1:0] irqs_in,
  input  logic                wr,
  input  logic [1:0]          addr,
  input  logic [15:0]         din,
  output logic [15:0]         dout,
  output logic                irq_assert,
  output logic [3:0]          irq_vector
);

  localparam logic [1:0] ADDR_ENABLED = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_MODE    = 2'd2;
  localparam logic [1:0] ADDR_VECTOR  = 2'd3;

  logic [NUM_IRQS-1:0] s_in;
  logic [NUM_IRQS-1:0] s_prev_q, s_prev_d;
  logic [NUM_IRQS-1:0] pending_q, pending_d;
  logic [NUM_IRQS-1:0] enabled_q, enabled_d;
  logic [NUM_IRQS-1:0] mode_q, mode_d;
  logic [15:0]         dout_q, dout_d;
  logic [NUM_IRQS-1:0] mask, rise, wr_clr, ack_clr, clr;
  logic [NUM_IRQS-1:0] active;
  logic [3:0]          vec;
  logic [15:0]         vector_word;

  assign mask = din[NUM_IRQS-1:0];

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s_in = irqs_in;
    end else begin : g_sync
      logic [NUM_IRQS-1:0] sync_q [SYNC_STAGES];
      logic [NUM_IRQS-1:0] sync_d [SYNC_STAGES];

      // Shift the raw inputs one stage down the chain each cycle.
      always_comb begin
        sync_d[0] = irqs_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      // Synchroniser flops.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
          end
        end
      end

      assign s_in = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign active = pending_q & enabled_q;

`ifdef IRQ_VECTOR_EN
  function automatic logic [3:0] lowest_index(input logic [NUM_IRQS-1:0] bits);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_IRQS - 1; i >= 0; i--) begin
      if (bits[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  assign vec         = lowest_index(active);
  assign vector_word = {|active, 11'b0, vec};

  // Acknowledge clears only the channel currently named by the vector.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_IRQS; i++) begin
      ack_clr[i] = wr && (addr == ADDR_VECTOR) && (|active) && (vec == 4'(i));
    end
  end
`else
  assign vec         = 4'd0;
  assign vector_word = 16'h0000;
  assign ack_clr     = '0;
`endif

  // Register-write decode and next-state of enable, mode and pending bits.
  always_comb begin
    enabled_d = enabled_q;
    mode_d    = mode_q;
    wr_clr    = '0;
    if (wr) begin
      case (addr)
        ADDR_ENABLED: enabled_d = din[15] ? (enabled_q | mask) : (enabled_q & ~mask);
        ADDR_PENDING: wr_clr    = mask;
        ADDR_MODE:    mode_d    = din[15] ? (mode_q | mask) : (mode_q & ~mask);
        ADDR_VECTOR:  wr_clr    = '0;
        default:      wr_clr    = '0;
      endcase
    end else begin
      wr_clr = '0;
    end
    clr      = wr_clr | ack_clr;
    rise     = s_in & ~s_prev_q;
    s_prev_d = s_in;
    // Edge wins over a same-cycle clear; a mode change drops the pending bit outright.
    pending_d = (mode_q & s_in) | (~mode_q & (rise | (pending_q & ~clr)));
    pending_d = pending_d & ~(mode_d ^ mode_q);
  end

  // Read mux: dout only moves on read cycles.
  always_comb begin
    dout_d = dout_q;
    if (!wr) begin
      case (addr)
        ADDR_ENABLED: dout_d = 16'(enabled_q);
        ADDR_PENDING: dout_d = 16'(pending_q);
        ADDR_MODE:    dout_d = 16'(mode_q);
        ADDR_VECTOR:  dout_d = vector_word;
        default:      dout_d = 16'h0000;
      endcase
    end else begin
      dout_d = dout_q;
    end
  end

  // State flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_prev_q  <= '0;
      pending_q <= '0;
      enabled_q <= '0;
      mode_q    <= '0;
      dout_q    <= 16'h0000;
    end else begin
      s_prev_q  <= s_prev_d;
      pending_q <= pending_d;
      enabled_q <= enabled_d;
      mode_q    <= mode_d;
      dout_q    <= dout_d;
    end
  end

  assign dout       = dout_q;
  assign irq_assert = |active;
  assign irq_vector = vec;

endmodule

// File: tb/tb_vectored_irq_controller.sv
// Self-checking bench: directed vector table, randomized run against a per-channel model,
// and hand sequences for synchroniser latency and asynchronous reset.
module tb_vectored_irq_controller;
  localparam int N = 15;
`ifdef IRQ_VECTOR_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [N-1:0]  irqs;
  logic          wr;
  logic [1:0]    addr;
  logic [15:0]   din;
  logic [15:0]   dout;
  logic          irq_assert;
  logic [3:0]    irq_vector;

  logic          reset2;
  logic [3:0]    irqs2;
  logic          wr2;
  logic [1:0]    addr2;
  logic [15:0]   din2;
  logic [15:0]   dout2;
  logic          assert2;
  logic [3:0]    vec2;

  vectored_irq_controller #(.NUM_IRQS(N), .SYNC_STAGES(0)) dut (
    .clk(clk), .reset(reset), .irqs_in(irqs), .wr(wr), .addr(addr), .din(din),
    .dout(dout), .irq_assert(irq_assert), .irq_vector(irq_vector)
  );

  vectored_irq_controller #(.NUM_IRQS(4), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .reset(reset2), .irqs_in(irqs2), .wr(wr2), .addr(addr2), .din(din2),
    .dout(dout2), .irq_assert(assert2), .irq_vector(vec2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one record per channel, rules applied channel by channel.
  bit          m_pend[N];
  bit          m_en[N];
  bit          m_mode[N];
  bit          m_prev[N];
  logic [15:0] m_dout;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0; m_en[i] = 1'b0; m_mode[i] = 1'b0; m_prev[i] = 1'b0;
    end
    m_dout = 16'h0000;
  endtask

  function automatic int m_top();
    for (int i = 0; i < N; i++) begin
      if (m_pend[i] && m_en[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [15:0] m_read(input logic [1:0] a);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < N; i++) begin
      if (a == 2'd0) r[i] = m_en[i];
      if (a == 2'd1) r[i] = m_pend[i];
      if (a == 2'd2) r[i] = m_mode[i];
    end
    if (a == 2'd3 && VEC_EN && m_top() >= 0) r = 16'h8000 | 16'(m_top());
    return r;
  endfunction

  task automatic model_step(input logic [N-1:0] ir, input logic w, input logic [1:0] a,
                            input logic [15:0] d);
    int top;
    bit nm, ne, np, clear;
    top = m_top();
    if (!w) m_dout = m_read(a);
    for (int i = 0; i < N; i++) begin
      nm = m_mode[i];
      ne = m_en[i];
      if (w && a == 2'd2 && d[i]) nm = d[15];
      if (w && a == 2'd0 && d[i]) ne = d[15];
      clear = w && ((a == 2'd1 && d[i]) || (a == 2'd3 && VEC_EN && top == i));
      if (nm != m_mode[i])             np = 1'b0;
      else if (m_mode[i])              np = ir[i];
      else if (ir[i] && !m_prev[i])    np = 1'b1;
      else if (clear)                  np = 1'b0;
      else                             np = m_pend[i];
      m_pend[i] = np; m_mode[i] = nm; m_en[i] = ne; m_prev[i] = ir[i];
    end
  endtask

  task automatic cyc(input logic [N-1:0] ir, input logic w, input logic [1:0] a,
                     input logic [15:0] d);
    irqs = ir; wr = w; addr = a; din = d;
    @(posedge clk);
    model_step(ir, w, a, d);
    #1;
  endtask

  task automatic cyc2(input logic [3:0] ir, input logic w, input logic [1:0] a,
                      input logic [15:0] d);
    irqs2 = ir; wr2 = w; addr2 = a; din2 = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0] irqs;
    logic         wr;
    logic [1:0]   addr;
    logic [15:0]  din;
    logic [15:0]  exp_dout;
    logic         exp_assert;
    logic [3:0]   exp_vec;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [3:0] v(input logic [3:0] x);
    return VEC_EN ? x : 4'd0;
  endfunction

  function automatic logic [15:0] vw(input logic [15:0] x);
    return VEC_EN ? x : 16'h0000;
  endfunction

  function automatic void rd(input logic [N-1:0] ir, input logic [1:0] a,
                             input logic [15:0] ed, input logic ea, input logic [3:0] ev);
    vec_t r;
    r.irqs = ir; r.wr = 1'b0; r.addr = a; r.din = 16'h0000;
    r.exp_dout = ed; r.exp_assert = ea; r.exp_vec = ev;
    tbl.push_back(r);
  endfunction

  function automatic void wrt(input logic [N-1:0] ir, input logic [1:0] a, input logic [15:0] d,
                              input logic [15:0] ed, input logic ea, input logic [3:0] ev);
    vec_t r;
    r.irqs = ir; r.wr = 1'b1; r.addr = a; r.din = d;
    r.exp_dout = ed; r.exp_assert = ea; r.exp_vec = ev;
    tbl.push_back(r);
  endfunction

  initial begin
    // Reset state and edge channel 2.
    rd (15'h0000, 2'd0,           16'h0000, 1'b0, 4'd0);
    rd (15'h0000, 2'd1,           16'h0000, 1'b0, 4'd0);
    rd (15'h0000, 2'd2,           16'h0000, 1'b0, 4'd0);
    wrt(15'h0000, 2'd0, 16'h8004, 16'h0000, 1'b0, 4'd0);
    rd (15'h0004, 2'd1,           16'h0000, 1'b1, v(4'd2));
    rd (15'h0000, 2'd1,           16'h0004, 1'b1, v(4'd2));
    wrt(15'h0000, 2'd1, 16'h0004, 16'h0004, 1'b0, 4'd0);
    rd (15'h0004, 2'd0,           16'h0004, 1'b1, v(4'd2));
    wrt(15'h0004, 2'd1, 16'h0004, 16'h0004, 1'b0, 4'd0);
    for (int k = 0; k < 10; k++) rd(15'h0004, 2'd1, 16'h0000, 1'b0, 4'd0);
    rd (15'h0000, 2'd1,           16'h0000, 1'b0, 4'd0);
    // Clear and edge in the same cycle on channel 5.
    wrt(15'h0000, 2'd0, 16'h8020, 16'h0000, 1'b0, 4'd0);
    rd (15'h0020, 2'd1,           16'h0000, 1'b1, v(4'd5));
    rd (15'h0000, 2'd1,           16'h0020, 1'b1, v(4'd5));
    wrt(15'h0020, 2'd1, 16'h0020, 16'h0020, 1'b1, v(4'd5));
    rd (15'h0000, 2'd1,           16'h0020, 1'b1, v(4'd5));
    wrt(15'h0000, 2'd1, 16'h0020, 16'h0020, 1'b0, 4'd0);
    // Level channel 3.
    wrt(15'h0000, 2'd2, 16'h8008, 16'h0020, 1'b0, 4'd0);
    wrt(15'h0000, 2'd0, 16'h8008, 16'h0020, 1'b0, 4'd0);
    rd (15'h0008, 2'd2,           16'h0008, 1'b1, v(4'd3));
    wrt(15'h0008, 2'd1, 16'h0008, 16'h0008, 1'b1, v(4'd3));
    rd (15'h0000, 2'd1,           16'h0008, 1'b0, 4'd0);
    rd (15'h0000, 2'd1,           16'h0000, 1'b0, 4'd0);
    wrt(15'h0000, 2'd2, 16'h0008, 16'h0000, 1'b0, 4'd0);
    // Vector and acknowledge on channels 1, 4, 9.
    wrt(15'h0000, 2'd0, 16'h8212, 16'h0000, 1'b0, 4'd0);
    rd (15'h0212, 2'd1,           16'h0000, 1'b1, v(4'd1));
    rd (15'h0000, 2'd3,           vw(16'h8001), 1'b1, v(4'd1));
    wrt(15'h0000, 2'd3, 16'h0000, vw(16'h8001), 1'b1, v(4'd4));
    rd (15'h0000, 2'd3,           vw(16'h8004), 1'b1, v(4'd4));
    wrt(15'h0000, 2'd0, 16'h0010, vw(16'h8004), 1'b1, v(4'd9));
    rd (15'h0000, 2'd3,           vw(16'h8009), 1'b1, v(4'd9));
    wrt(15'h0000, 2'd3, 16'h0000, vw(16'h8009), !VEC_EN, 4'd0);
    rd (15'h0000, 2'd3,           16'h0000, !VEC_EN, 4'd0);
    wrt(15'h0000, 2'd3, 16'h0000, 16'h0000, !VEC_EN, 4'd0);
    rd (15'h0000, 2'd1,           VEC_EN ? 16'h0010 : 16'h0212, !VEC_EN, 4'd0);
    wrt(15'h0000, 2'd1, 16'hFFFF, VEC_EN ? 16'h0010 : 16'h0212, 1'b0, 4'd0);
    rd (15'h0000, 2'd1,           16'h0000, 1'b0, 4'd0);
    // Bits above the channel count are ignored and read as zero.
    wrt(15'h0000, 2'd0, 16'hFFFF, 16'h0000, 1'b0, 4'd0);
    rd (15'h0000, 2'd0,           16'h7FFF, 1'b0, 4'd0);
    wrt(15'h0000, 2'd0, 16'h7FFF, 16'h7FFF, 1'b0, 4'd0);
    rd (15'h0000, 2'd0,           16'h0000, 1'b0, 4'd0);
    wrt(15'h0000, 2'd2, 16'hFFFF, 16'h0000, 1'b0, 4'd0);
    rd (15'h0000, 2'd2,           16'h7FFF, 1'b0, 4'd0);
    wrt(15'h0000, 2'd2, 16'h7FFF, 16'h7FFF, 1'b0, 4'd0);
    rd (15'h0000, 2'd2,           16'h0000, 1'b0, 4'd0);

    reset = 1'b1; reset2 = 1'b1;
    irqs = '0; wr = 1'b0; addr = 2'd0; din = 16'h0000;
    irqs2 = '0; wr2 = 1'b0; addr2 = 2'd0; din2 = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset dout", dout, 16'h0000);
    check("reset assert", 16'(irq_assert), 16'h0000);
    check("reset vector", 16'(irq_vector), 16'h0000);
    check("reset2 dout", dout2, 16'h0000);

    // Two-stage synchroniser: latency, async reset mid-pulse, edge seen after release.
    reset2 = 1'b0;
    cyc2(4'h0, 1'b1, 2'd0, 16'h800F);
    check("s2 write holds dout", dout2, 16'h0000);
    cyc2(4'h0, 1'b0, 2'd0, 16'h0000);
    check("s2 enabled unused bits", dout2, 16'h000F);
    cyc2(4'h1, 1'b0, 2'd1, 16'h0000);
    check("s2 edge k", 16'(assert2), 16'h0000);
    cyc2(4'h1, 1'b0, 2'd1, 16'h0000);
    check("s2 edge k+1", 16'(assert2), 16'h0000);
    cyc2(4'h1, 1'b0, 2'd1, 16'h0000);
    check("s2 edge k+2 assert", 16'(assert2), 16'h0001);
    check("s2 edge k+2 dout", dout2, 16'h0000);
    cyc2(4'h1, 1'b0, 2'd1, 16'h0000);
    check("s2 pending read", dout2, 16'h0001);
    #2;
    reset2 = 1'b1;
    #1;
    check("s2 async reset dout", dout2, 16'h0000);
    check("s2 async reset assert", 16'(assert2), 16'h0000);
    check("s2 async reset vector", 16'(vec2), 16'h0000);
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    cyc2(4'h1, 1'b1, 2'd0, 16'h800F);
    check("s2 post-reset edge1", 16'(assert2), 16'h0000);
    cyc2(4'h1, 1'b0, 2'd1, 16'h0000);
    check("s2 post-reset edge2", 16'(assert2), 16'h0000);
    cyc2(4'h1, 1'b0, 2'd1, 16'h0000);
    check("s2 post-reset edge3", 16'(assert2), 16'h0001);
    cyc2(4'h0, 1'b0, 2'd1, 16'h0000);
    check("s2 post-reset pending", dout2, 16'h0001);

    // Directed table on the unsynchronised instance.
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < tbl.size(); k++) begin
      cyc(tbl[k].irqs, tbl[k].wr, tbl[k].addr, tbl[k].din);
      check($sformatf("row%0d dout", k), dout, tbl[k].exp_dout);
      check($sformatf("row%0d assert", k), 16'(irq_assert), 16'(tbl[k].exp_assert));
      check($sformatf("row%0d vector", k), 16'(irq_vector), 16'(tbl[k].exp_vec));
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      logic [N-1:0] r_ir;
      logic         r_w;
      logic [1:0]   r_a;
      logic [15:0]  r_d;
      int           top;
      r_ir = N'($urandom);
      r_w  = ($urandom_range(0, 2) == 0);
      r_a  = 2'($urandom_range(0, 3));
      r_d  = 16'($urandom);
      cyc(r_ir, r_w, r_a, r_d);
      top = m_top();
      check($sformatf("rand%0d dout", k), dout, m_dout);
      check($sformatf("rand%0d assert", k), 16'(irq_assert), (top >= 0) ? 16'h0001 : 16'h0000);
      check($sformatf("rand%0d vector", k), 16'(irq_vector),
            (VEC_EN && top >= 0) ? 16'(top) : 16'h0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
